mem_apb4_ws: RTL
================

Name: mem_apb4_ws

Overview:
Parametrised APB4 slave memory; next generation of the simple zero-wait APB memory model.
- Adds data width up to 64 bits.
- Adds independent programmable read and write wait states.
- Adds an address-range error response.
- Used as a bus-model target behind the AXI-to-APB bridge for timing and error-path testing.

Parameters:
- AW, 32, PADDR width.
- DW, 32, data width; 32 or 64 only.
- LEN, 10, log2 of memory size in bytes; DEPTH = 2^(LEN-log2(DS)) words.
- DS, DW/8, number of PSTRB bits.
- WAIT_RD, 0, number of wait cycles (PREADY low) in a read access phase; range 0..15.
- WAIT_WR, 0, number of wait cycles in a write access phase; range 0..15.
- BASE, 0, byte base address of the memory window.

Ports:
- PCLK  input  1  clock; all state changes on its rising edge.
- PRESET  input  1  asynchronous active-high reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase.
- PADDR  input  AW  byte address; low log2(DS) bits ignored.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  DW  write data.
- PSTRB  input  DS  write byte lanes.
- PPROT  input  3  protection attributes.
- PRDATA  output  DW  read data.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  error response; qualified by PREADY.

Behaviour:
- Reset (PRESET=1, asynchronous): state IDLE, wait counter 0, PRDATA=0, PREADY=0, PSLVERR=0. Memory contents not reset. Reset during a transfer aborts it with no memory update.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on PSEL & ~PENABLE (setup phase).
  - At that edge: counter <= PWRITE ? WAIT_WR : WAIT_RD; address-error flag latched.
  - ACCESS: counter decrements each cycle while non-zero.
  - ACCESS -> IDLE on the edge where PSEL & PENABLE & PREADY.
  - ACCESS -> IDLE if PSEL falls (protocol violation); no write, no error.
- PREADY = (state==ACCESS) & (counter==0); combinational from registers, no input paths.
- Access-phase length: exactly WAIT+1 cycles. WAIT=0 gives zero-wait behaviour identical to the legacy block.
- Address error: (PADDR - BASE) >= 2^LEN, or PADDR < BASE. Latched at setup.
- PSLVERR = PREADY & err_flag. On error: no write; PRDATA forced 0.
- Write: performed on the completing edge (PSEL & PENABLE & PREADY & PWRITE & ~err). Only lanes with PSTRB[i]=1 are updated; the others keep their old value (per-lane read-modify-write of the word at TA). PSTRB all-zero means no change, PSLVERR=0.
- Read: PRDATA <= mem[TA] on every edge where PSEL & ~PWRITE & ~(PENABLE & PREADY), so PRDATA is valid throughout the ready cycle. PRDATA holds its value otherwise. PSTRB ignored on reads.
- Back-to-back: a new setup phase in the cycle after completion is accepted; there are no dead cycles.
- TA = (PADDR - BASE)[LEN-1:log2(DS)]; wraps within the window only via the error check (no aliasing).

Optional Feature:
MEM_APB4_PROT_EN
- Defined: a write with PPROT[0]=0 (unprivileged) to the upper half of the window (TA MSB=1) completes with PSLVERR=1 and no memory update. Reads are unaffected.
- Undefined: PPROT ignored entirely.

Decomposition:
- Package mem_apb4_pkg holds:
  - state encoding (IDLE=1'b0, ACCESS=1'b1);
  - wait-counter width constant CNT_W=4;
  - function computing log2(DS).
- Sub-module mem_apb4_wait_ctrl holds the FSM, wait counter, error flag and PREADY/PSLVERR generation.
- Top level holds the memory array, strobe merge and PRDATA register.

Test Plan:
- WAIT_RD=0, WAIT_WR=0: write 0xDEADBEEF at 0x10, then read 0x10 -> PREADY high in the first access cycle; PRDATA=0xDEADBEEF; PSLVERR=0.
- WAIT_WR=3, WAIT_RD=2: write then read 0x20 -> PREADY low for 3 and 2 access cycles respectively; data 0x12345678 returned on the ready cycle.
- Preload 0xFFFFFFFF; write 0x00AA0000 with PSTRB=4'b0100, then read -> 0xFFAAFFFF.
- LEN=10, BASE=0: write then read 0x400 -> PSLVERR=1 with PREADY; read PRDATA=0; in-range locations unchanged.
- Assert PRESET mid-access with WAIT_WR=5 -> PREADY=0, PSLVERR=0, PRDATA=0 immediately; target word unchanged.
- With MEM_APB4_PROT_EN: write at TA MSB=1 with PPROT=3'b000 -> PSLVERR=1, no update. Same write with PPROT=3'b001 -> succeeds.

Source files
------------

// File: rtl/mem_apb4_pkg.sv
// Shared types and constants for the wait-state APB4 memory model.
package mem_apb4_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int unsigned CNT_W = 4;

  // Byte-lane count to word-offset bit count (DS is a power of two).
  function automatic int unsigned ds_log2(input int unsigned ds);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) < ds) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_apb4_wait_ctrl.sv
// APB4 transfer sequencer: FSM, programmable wait counter, error flag, PREADY/PSLVERR.
// Optional MEM_APB4_PROT_EN adds unprivileged-write protection of the upper window half.
module mem_apb4_wait_ctrl
  import mem_apb4_pkg::*;
#(
  parameter int unsigned   AW      = 32,
  parameter int unsigned   LEN     = 10,
  parameter int unsigned   OFF     = 2,
  parameter int unsigned   WAIT_RD = 0,
  parameter int unsigned   WAIT_WR = 0,
  parameter logic [AW-1:0] BASE    = '0
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [AW-1:0]     paddr,
  input  logic [2:0]        pprot,
  output logic [LEN-OFF-1:0] ta,
  output logic              range_err,
  output logic              err_flag,
  output logic              pready,
  output logic              pslverr
);

  localparam logic [CNT_W-1:0] RdInit = CNT_W'(WAIT_RD);
  localparam logic [CNT_W-1:0] WrInit = CNT_W'(WAIT_WR);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic [AW-1:0]    off;
  logic             below;
  logic             setup_err;
  logic             unused_off;

  // Borrow out of the subtraction flags PADDR < BASE without a constant compare.
  assign {below, off} = {1'b0, paddr} - {1'b0, BASE};
  assign range_err    = below | (|off[AW-1:LEN]);
  assign ta           = off[LEN-1:OFF];
  assign unused_off   = ^off[OFF-1:0];

`ifdef MEM_APB4_PROT_EN
  logic unused_prot;
  assign unused_prot = ^pprot[2:1];
  assign setup_err   = range_err | (pwrite & ~pprot[0] & off[LEN-1]);
`else
  logic unused_prot;
  assign unused_prot = ^pprot;
  assign setup_err   = range_err;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            state_q <= ACCESS;
            cnt_q   <= pwrite ? WrInit : RdInit;
            err_q   <= setup_err;
          end
        end
        ACCESS: begin
          // Dropping PSEL mid-access abandons the transfer silently.
          if (!psel || (penable && pready)) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pready   = (state_q == ACCESS) && (cnt_q == '0);
  assign pslverr  = pready & err_q;
  assign err_flag = err_q;

endmodule

// File: rtl/mem_apb4_ws.sv
// APB4 slave memory with programmable read/write wait states and address-range errors.
// Define MEM_APB4_PROT_EN to reject unprivileged writes to the upper half of the window.
module mem_apb4_ws
  import mem_apb4_pkg::*;
#(
  parameter int unsigned   AW      = 32,
  parameter int unsigned   DW      = 32,
  parameter int unsigned   LEN     = 10,
  parameter int unsigned   DS      = DW / 8,
  parameter int unsigned   WAIT_RD = 0,
  parameter int unsigned   WAIT_WR = 0,
  parameter logic [AW-1:0] BASE    = '0
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic [AW-1:0] PADDR,
  input  logic          PWRITE,
  input  logic [DW-1:0] PWDATA,
  input  logic [DS-1:0] PSTRB,
  input  logic [2:0]    PPROT,
  output logic [DW-1:0] PRDATA,
  output logic          PREADY,
  output logic          PSLVERR
);

  localparam int unsigned OFF   = ds_log2(DS);
  localparam int unsigned TW    = LEN - OFF;
  localparam int unsigned DEPTH = 1 << TW;

  logic [DW-1:0] mem [DEPTH];
  logic [TW-1:0] ta;
  logic          range_err;
  logic          err_flag;
  logic          wr_en;
  logic          rd_en;

  mem_apb4_wait_ctrl #(
    .AW     (AW),
    .LEN    (LEN),
    .OFF    (OFF),
    .WAIT_RD(WAIT_RD),
    .WAIT_WR(WAIT_WR),
    .BASE   (BASE)
  ) u_ctrl (
    .pclk     (PCLK),
    .preset   (PRESET),
    .psel     (PSEL),
    .penable  (PENABLE),
    .pwrite   (PWRITE),
    .paddr    (PADDR),
    .pprot    (PPROT),
    .ta       (ta),
    .range_err(range_err),
    .err_flag (err_flag),
    .pready   (PREADY),
    .pslverr  (PSLVERR)
  );

  assign wr_en = PSEL & PENABLE & PREADY & PWRITE & ~err_flag;
  // Reload through setup and wait cycles so PRDATA is stable in the ready cycle.
  assign rd_en = PSEL & ~PWRITE & ~(PENABLE & PREADY);

  always_ff @(posedge PCLK) begin
    if (wr_en) begin
      for (int i = 0; i < DS; i++) begin
        if (PSTRB[i]) mem[ta][8*i +: 8] <= PWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PRDATA <= '0;
    end else if (rd_en) begin
      PRDATA <= range_err ? '0 : mem[ta];
    end
  end

endmodule
